// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: entry-count state encoding
// and the default payload width.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with a synchronous flush (clr).
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no payload held, main = skid = BUBBLE
// ONE   | main holds the head payload, skid = BUBBLE
// TWO   | main holds the head, skid holds the next one
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;

  // Handshake outputs decode only the state register, never an input.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (clr) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            w_main_nxt = in_data;
          end else if (in_valid) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_TWO;
          end else if (out_ready) begin
            w_main_nxt  = BUBBLE;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, then a long random run
// checked against a queue model of the two-entry stage.
module tb_pipe_stage_skid;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          clr;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] d;
    logic          e_valid;
    logic          e_ready;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[$];
  logic [DW-1:0] model_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic iv, input logic o,
                     input logic [DW-1:0] d, input logic ev, input logic er,
                     input logic [1:0] eo, input logic [DW-1:0] ed);
    vec_t v;
    v.rst = r; v.clr = c; v.iv = iv; v.ordy = o; v.d = d;
    v.e_valid = ev; v.e_ready = er; v.e_occ = eo; v.e_data = ed;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic er,
                            input logic [1:0] eo, input logic [DW-1:0] ed);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(ev));
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(er));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(eo));
    chk({tag, ".out_data"},  out_data,       ed);
  endtask

  // Reference: a FIFO of at most two payloads, updated once per edge.
  task automatic model_edge(input logic r, input logic c, input logic iv,
                            input logic o, input logic [DW-1:0] d);
    bit acc, pop;
    acc = iv && (model_q.size() < 2);
    pop = (model_q.size() > 0) && o;
    if (r || c) model_q.delete();
    else begin
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // reset, release
    add(1,0,0,0,16'h0000, 0,1,0,16'h0000);
    add(1,0,0,0,16'h0000, 0,1,0,16'h0000);
    add(0,0,0,0,16'h0000, 0,1,0,16'h0000);
    // streaming at full rate
    add(0,0,1,1,16'h0011, 1,1,1,16'h0011);
    add(0,0,1,1,16'h0022, 1,1,1,16'h0022);
    add(0,0,1,1,16'h0033, 1,1,1,16'h0033);
    add(0,0,0,1,16'h0000, 0,1,0,16'h0000);
    // fill skid, then drain in order; offered 0xC ignored while full
    add(0,0,1,0,16'h000A, 1,1,1,16'h000A);
    add(0,0,1,0,16'h000B, 1,0,2,16'h000A);
    add(0,0,1,0,16'h00EE, 1,0,2,16'h000A);
    add(0,0,1,1,16'h000C, 1,1,1,16'h000B);
    add(0,0,0,1,16'h0000, 0,1,0,16'h0000);
    // clr in TWO discards both entries and the offered input
    add(0,0,1,0,16'h000A, 1,1,1,16'h000A);
    add(0,0,1,0,16'h000B, 1,0,2,16'h000A);
    add(0,1,1,1,16'h0055, 0,1,0,16'h0000);
    add(0,0,0,1,16'h0000, 0,1,0,16'h0000);
    // rst and clr together win over an accepting handshake
    add(0,0,1,0,16'h0077, 1,1,1,16'h0077);
    add(1,1,1,1,16'h0088, 0,1,0,16'h0000);
    add(0,0,0,1,16'h0000, 0,1,0,16'h0000);
    // ONE with input and no output ready, then clr with ONE -> EMPTY
    add(0,0,1,0,16'h1234, 1,1,1,16'h1234);
    add(0,1,0,0,16'h0000, 0,1,0,16'h0000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; clr = vecs[i].clr; in_valid = vecs[i].iv;
      out_ready = vecs[i].ordy; in_data = vecs[i].d;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                 vecs[i].e_occ, vecs[i].e_data);
    end

    // Hand sequence: rst while TWO drops both entries, no partial transfer.
    rst = 0; clr = 0; out_ready = 0; in_valid = 1; in_data = 16'h0101;
    @(posedge clk); #1;
    in_data = 16'h0202;
    @(posedge clk); #1;
    check_outs("two_before_rst", 1, 0, 2, 16'h0101);
    rst = 1; out_ready = 1; in_valid = 0;
    @(posedge clk); #1;
    check_outs("rst_in_two", 0, 1, 0, 16'h0000);
    rst = 0; out_ready = 1;
    @(posedge clk); #1;
    check_outs("after_rst_in_two", 0, 1, 0, 16'h0000);

    // Random run against the queue model.
    model_q.delete();
    begin
      int consumed = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        logic ir_a, ir_b;
        rst       = 1'b0;
        clr       = ($urandom_range(0, 299) == 0);
        in_valid  = ($urandom_range(0, 99) < 65);
        out_ready = ($urandom_range(0, 99) < 60);
        in_data   = DW'($urandom);
        #1 ir_a = in_ready;
        out_ready = ~out_ready;
        #1 ir_b = in_ready;
        out_ready = ~out_ready;
        chk("in_ready_vs_out_ready", DW'(ir_b), DW'(ir_a));
        if (out_valid && out_ready && !clr) consumed++;
        model_edge(rst, clr, in_valid, out_ready, in_data);
        @(posedge clk); #1;
        check_outs($sformatf("rnd%0d", cyc),
                   model_q.size() > 0, model_q.size() < 2,
                   2'(model_q.size()),
                   (model_q.size() > 0) ? model_q[0] : DW'(0));
      end
      chk("rnd_consumed_nonzero", DW'(consumed > 1000), DW'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width (instruction + pc_plus_4 for the decode stage).
REQ-002 SHALL have parameter BUBBLE, default {DATA_W{1'b0}}, meaning the payload value presented when empty or cleared.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clr  input  1  synchronous flush from the hazard unit.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  block can accept; registered, not a function of any input.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; the hazard unit drives ~stall here.
REQ-011 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-012 SHALL have port occupancy  output  2  entries held, 0..2.

Function
REQ-013 SHALL hold two entries: main, which drives out_data, and skid; the states are EMPTY, ONE and TWO.
REQ-014 SHALL accept input when in_valid & in_ready, and transfer output when out_valid & out_ready, on the same rising edge.
REQ-015 SHALL drive in_ready = (state != TWO), out_valid = (state != EMPTY), and occupancy = 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-016 In EMPTY, in_valid SHALL load main and move the block to ONE.
REQ-017 In ONE, the block SHALL behave as follows:
- in_valid & out_ready: load main from in_data, stay in ONE.
- in_valid & !out_ready: load skid, go to TWO.
- !in_valid & out_ready: go to EMPTY.
- neither asserted: hold.
REQ-018 In TWO, out_ready SHALL copy skid to main and move to ONE; in_valid SHALL be ignored because in_ready = 0.
REQ-019 SHALL give one cycle of latency: data accepted at edge N is on out_data after edge N; sustained full throughput SHALL be one transfer per cycle.
REQ-020 out_data SHALL equal BUBBLE whenever out_valid = 0.
REQ-021 A payload SHALL NOT be lost, duplicated or reordered under any in_valid/out_ready pattern.
REQ-022 clr SHALL move the block to EMPTY with main = skid = BUBBLE at the next edge, overriding all handshakes.
REQ-023 An input offered in a clr cycle SHALL be discarded, and an output "transfer" in a clr cycle SHALL count as consumed.
REQ-024 rst SHALL take priority over clr; simultaneous rst and clr SHALL produce the reset state.
REQ-025 The skid entry SHALL be BUBBLE whenever the state is not TWO.

Reset
REQ-026 On rst the block SHALL set state = EMPTY, main = skid = BUBBLE, out_valid = 0, in_ready = 1 and occupancy = 0 at the next edge.
REQ-027 rst mid-operation, in any state, SHALL discard both entries with no partial transfer.
REQ-028 No initial blocks SHALL be relied on for reset values.

Structure
REQ-029 The state encoding (EMPTY = 0, ONE = 1, TWO = 2) and the DATA_W default SHALL live in shared package pipe_pkg, for reuse by the later stage registers.
REQ-030 The block SHALL be a single module with no sub-modules; the decode, execute, memory and writeback stage registers SHALL instantiate it with their own DATA_W.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- rst for 2 cycles, then release -> out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0.
- Stream 0x11, 0x22, 0x33 with out_ready = 1 -> each appears one cycle later, occupancy stays 1, in_ready stays 1.
- Send 0xA then 0xB with out_ready = 0 -> occupancy 2, in_ready = 0, out_data = 0xA; raise out_ready -> 0xA then 0xB in order, back to EMPTY.
- In TWO, assert clr -> next cycle EMPTY, out_data = BUBBLE, in_ready = 1; in_valid offered in the clr cycle is not emitted.
- rst and clr together with out_ready = 1 -> reset state; a random 10k-cycle in_valid/out_ready run -> the scoreboard shows an in-order, lossless stream and in_ready never depends combinationally on out_ready.
